mem_arbiter: RTL and testbench

Shares the core's single-ported synchronous RAM between the instruction-fetch port (read-only) and the load/store data port (read/write with byte strobes).
- One transaction outstanding at a time.
- Data port has priority; a streak counter guarantees fetch forward progress.
- Sits between the core's fetch/LSU logic and the ram block; sequences the RAM enable, waits out its read latency, and returns the response to the winning port.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data request and response signals plus the RAM access bus.
// The arbiter uses the slave view; the core/RAM environment uses the master view.
interface mem_arbiter_if;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rdata;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_rsp_valid;
  logic [31:0] d_rdata;

  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;

  logic        busy;

  modport slave (
    input  i_req_valid, i_addr,
    input  d_req_valid, d_we, d_addr, d_wdata, d_wstrb,
    input  m_rdata,
    output i_req_ready, i_rsp_valid, i_rdata,
    output d_req_ready, d_rsp_valid, d_rdata,
    output m_en, m_we, m_addr, m_wdata, m_wstrb,
    output busy
  );

  modport master (
    output i_req_valid, i_addr,
    output d_req_valid, d_we, d_addr, d_wdata, d_wstrb,
    output m_rdata,
    input  i_req_ready, i_rsp_valid, i_rdata,
    input  d_req_ready, d_rsp_valid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_wstrb,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one synchronous RAM between instruction
// fetch (read-only) and the load/store port; data has priority, bounded by a streak limit.
module mem_arbiter #(
  parameter int unsigned RAM_LAT     = 1,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [3:0] LAT_LAST   = 4'(RAM_LAT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  streak_reg, streak_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        sel_data_reg, sel_data_next;
  logic        is_store_reg, is_store_next;

  logic        m_en_reg, m_en_next;
  logic        m_we_reg, m_we_next;
  logic [31:0] m_addr_reg, m_addr_next;
  logic [31:0] m_wdata_reg, m_wdata_next;
  logic [3:0]  m_wstrb_reg, m_wstrb_next;

  logic [31:0] i_rdata_reg, i_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;

  logic        idle;
  logic        grant_d;
  logic        grant_i;

  // Fetch only overtakes a waiting data request once the data streak hits its limit.
  assign idle    = (state_reg == IDLE);
  assign grant_d = idle && bus.d_req_valid &&
                   !(bus.i_req_valid && (streak_reg == STREAK_MAX));
  assign grant_i = idle && bus.i_req_valid && !grant_d;

  always_comb begin
    state_next    = state_reg;
    streak_next   = streak_reg;
    wait_cnt_next = wait_cnt_reg;
    sel_data_next = sel_data_reg;
    is_store_next = is_store_reg;
    m_en_next     = 1'b0;
    m_we_next     = 1'b0;
    m_wstrb_next  = 4'h0;
    m_addr_next   = m_addr_reg;
    m_wdata_next  = m_wdata_reg;
    i_rdata_next  = i_rdata_reg;
    d_rdata_next  = d_rdata_reg;

    unique case (state_reg)
      IDLE: begin
        if (grant_d) begin
          sel_data_next = 1'b1;
          is_store_next = bus.d_we;
          m_en_next     = 1'b1;
          m_we_next     = bus.d_we;
          m_addr_next   = bus.d_addr;
          m_wdata_next  = bus.d_wdata;
          m_wstrb_next  = bus.d_wstrb;
          streak_next   = bus.i_req_valid ? (streak_reg + 4'd1) : 4'd0;
          state_next    = ISSUE;
        end else if (grant_i) begin
          sel_data_next = 1'b0;
          is_store_next = 1'b0;
          m_en_next     = 1'b1;
          m_we_next     = 1'b0;
          m_addr_next   = bus.i_addr & 32'hFFFF_FFFC;
          m_wdata_next  = 32'h0;
          m_wstrb_next  = 4'h0;
          streak_next   = 4'd0;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_next = LAT_LAST;
        state_next    = WAIT;
      end
      WAIT: begin
        // The final WAIT cycle is the one in which the RAM presents its data.
        if (wait_cnt_reg == 4'd0) begin
          state_next = RESP;
          if (!is_store_reg) begin
            if (sel_data_reg) begin
              d_rdata_next = bus.m_rdata;
            end else begin
              i_rdata_next = bus.m_rdata;
            end
          end
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      streak_reg   <= 4'd0;
      wait_cnt_reg <= 4'd0;
      sel_data_reg <= 1'b0;
      is_store_reg <= 1'b0;
      m_en_reg     <= 1'b0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= 32'h0;
      m_wdata_reg  <= 32'h0;
      m_wstrb_reg  <= 4'h0;
      i_rdata_reg  <= 32'h0;
      d_rdata_reg  <= 32'h0;
    end else begin
      state_reg    <= state_next;
      streak_reg   <= streak_next;
      wait_cnt_reg <= wait_cnt_next;
      sel_data_reg <= sel_data_next;
      is_store_reg <= is_store_next;
      m_en_reg     <= m_en_next;
      m_we_reg     <= m_we_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      m_wstrb_reg  <= m_wstrb_next;
      i_rdata_reg  <= i_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  // Ready is forced low while reset is held so every output reads zero.
  assign bus.i_req_ready = grant_i && !rst;
  assign bus.d_req_ready = grant_d && !rst;
  assign bus.i_rsp_valid = (state_reg == RESP) && !sel_data_reg;
  assign bus.d_rsp_valid = (state_reg == RESP) &&  sel_data_reg;
  assign bus.i_rdata     = i_rdata_reg;
  assign bus.d_rdata     = d_rdata_reg;
  assign bus.m_en        = m_en_reg;
  assign bus.m_we        = m_we_reg;
  assign bus.m_addr      = m_addr_reg;
  assign bus.m_wdata     = m_wdata_reg;
  assign bus.m_wstrb     = m_wstrb_reg;
  assign bus.busy        = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: RAM_LAT=1 instance for the main traffic,
// RAM_LAT=3 instance for the long-latency load case.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } m_t;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.RAM_LAT(1), .MAX_DSTREAK(4)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  mem_arbiter #(.RAM_LAT(3), .MAX_DSTREAK(4)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  function automatic logic [31:0] pat(input int w);
    return 32'hA000_0000 | (32'(w) << 16) | 32'(w);
  endfunction

  // RAM models: read data appears only in the exact latency cycle, garbage otherwise
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic        a_pv = 1'b0;
  logic [31:0] a_pd;
  logic [2:0]  b_pv = 3'b000;
  logic [31:0] b_pd [0:2];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 256; k++) mem_a[k] <= (k == 8'h41) ? 32'hDEAD_BEEF : pat(k);
    end else if (bus_a.m_en && bus_a.m_we) begin
      for (int b = 0; b < 4; b++)
        if (bus_a.m_wstrb[b]) mem_a[bus_a.m_addr[9:2]][8*b +: 8] <= bus_a.m_wdata[8*b +: 8];
    end
    a_pv <= bus_a.m_en && !bus_a.m_we;
    a_pd <= mem_a[bus_a.m_addr[9:2]];
  end
  assign bus_a.m_rdata = a_pv ? a_pd : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (init_mem)
      for (int k = 0; k < 256; k++) mem_b[k] <= (k == 12) ? 32'hA5A5_A5A5 : pat(k);
    b_pv    <= {b_pv[1:0], bus_b.m_en && !bus_b.m_we};
    b_pd[0] <= mem_b[bus_b.m_addr[9:2]];
    b_pd[1] <= b_pd[0];
    b_pd[2] <= b_pd[1];
  end
  assign bus_b.m_rdata = b_pv[2] ? b_pd[2] : 32'hBAD0_BAD0;

  // Scoreboard queues
  logic [31:0] i_rsp_q[$];
  logic [31:0] d_rsp_q[$];
  logic [31:0] b_rsp_q[$];
  m_t          i_m_q[$];
  m_t          d_m_q[$];
  int          i_acc_q[$];
  int          d_acc_q[$];
  int          b_acc_q[$];
  byte         grant_log[$];
  logic        last_grant_d = 1'b0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor for the RAM_LAT=1 instance
  always @(negedge clk) begin
    logic [31:0] e;
    m_t          m;
    if (rst) begin
      i_acc_q.delete();
      d_acc_q.delete();
    end else begin
      if (bus_a.i_req_ready || bus_a.d_req_ready) begin
        check("single_grant", bus_a.i_req_ready & bus_a.d_req_ready, 0);
        if (bus_a.i_req_ready) begin grant_log.push_back(8'h49); i_acc_q.push_back(cyc); end
        if (bus_a.d_req_ready) begin grant_log.push_back(8'h44); d_acc_q.push_back(cyc); end
        last_grant_d <= bus_a.d_req_ready;
      end
      if (bus_a.m_en) begin
        if (last_grant_d ? (d_m_q.size() == 0) : (i_m_q.size() == 0))
          flag("m_access", "unexpected RAM access");
        else begin
          m = last_grant_d ? d_m_q.pop_front() : i_m_q.pop_front();
          check(last_grant_d ? "d_m_fields" : "i_m_fields",
                {bus_a.m_we, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb}, m);
        end
      end
      if (bus_a.i_rsp_valid) begin
        check("rsp_exclusive", bus_a.d_rsp_valid, 0);
        if (i_rsp_q.size() == 0) flag("i_rsp", "response with none outstanding");
        else begin
          e = i_rsp_q.pop_front();
          check("i_rdata", bus_a.i_rdata, e);
          if (i_acc_q.size() != 0) check("i_latency", cyc - i_acc_q.pop_front(), 3);
          else flag("i_latency", "no accept recorded");
        end
      end
      if (bus_a.d_rsp_valid) begin
        if (d_rsp_q.size() == 0) flag("d_rsp", "response with none outstanding");
        else begin
          e = d_rsp_q.pop_front();
          check("d_rdata", bus_a.d_rdata, e);
          if (d_acc_q.size() != 0) check("d_latency", cyc - d_acc_q.pop_front(), 3);
          else flag("d_latency", "no accept recorded");
        end
      end
    end
  end

  // Monitor for the RAM_LAT=3 instance
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (bus_b.d_req_ready) b_acc_q.push_back(cyc);
      if (bus_b.i_rsp_valid) flag("b_i_rsp", "unexpected fetch response");
      if (bus_b.d_rsp_valid) begin
        if (b_rsp_q.size() == 0) flag("b_d_rsp", "response with none outstanding");
        else begin
          e = b_rsp_q.pop_front();
          check("b_d_rdata", bus_b.d_rdata, e);
          if (b_acc_q.size() != 0) check("b_latency", cyc - b_acc_q.pop_front(), 5);
          else flag("b_latency", "no accept recorded");
        end
      end
    end
  end

  task automatic wait_ready_a(input logic is_data);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_data ? bus_a.d_req_ready : bus_a.i_req_ready) && n < 200);
    tests_run++;
    if (!(is_data ? bus_a.d_req_ready : bus_a.i_req_ready)) begin
      tests_failed++;
      $display("FAIL accept_timeout: port=%s never accepted", is_data ? "data" : "fetch");
    end
    @(posedge clk);
    #1;
  endtask

  // Request helpers leave valid asserted so callers can chain back-to-back requests
  task automatic a_fetch_req(input logic [31:0] addr, input logic [31:0] exp);
    m_t m;
    m = {1'b0, addr & 32'hFFFF_FFFC, 32'h0, 4'h0};
    i_rsp_q.push_back(exp);
    i_m_q.push_back(m);
    bus_a.i_addr      = addr;
    bus_a.i_req_valid = 1'b1;
    wait_ready_a(1'b0);
  endtask

  task automatic a_data_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] exp);
    m_t m;
    m = {we, addr, wdata, strb};
    d_rsp_q.push_back(exp);
    d_m_q.push_back(m);
    bus_a.d_we        = we;
    bus_a.d_addr      = addr;
    bus_a.d_wdata     = wdata;
    bus_a.d_wstrb     = strb;
    bus_a.d_req_valid = 1'b1;
    wait_ready_a(1'b1);
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while ((i_rsp_q.size() != 0 || d_rsp_q.size() != 0 || bus_a.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 100) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d fetch, %0d data responses missing", i_rsp_q.size(), d_rsp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic a_fetch(input logic [31:0] addr, input logic [31:0] exp);
    a_fetch_req(addr, exp);
    bus_a.i_req_valid = 1'b0;
    drain_a();
  endtask

  task automatic a_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp);
    a_data_req(we, addr, wdata, strb, exp);
    bus_a.d_req_valid = 1'b0;
    drain_a();
  endtask

  task automatic zero_check(input string name, input logic [10:0] ctl, input logic [31:0] ma,
                            input logic [31:0] mw, input logic [31:0] ir, input logic [31:0] dr);
    check({name, "_ctl"}, ctl, 0);
    check({name, "_m_addr"}, ma, 0);
    check({name, "_m_wdata"}, mw, 0);
    check({name, "_i_rdata"}, ir, 0);
    check({name, "_d_rdata"}, dr, 0);
  endtask

  task automatic zero_a(input string name);
    zero_check(name, {bus_a.busy, bus_a.i_req_ready, bus_a.d_req_ready, bus_a.m_en, bus_a.m_we,
                      bus_a.i_rsp_valid, bus_a.d_rsp_valid, bus_a.m_wstrb},
               bus_a.m_addr, bus_a.m_wdata, bus_a.i_rdata, bus_a.d_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_order;
    int    n;
    m_t    m;

    bus_a.i_req_valid = 1'b0; bus_a.i_addr = 32'h0;
    bus_a.d_req_valid = 1'b0; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h0;
    bus_a.d_wdata = 32'h0; bus_a.d_wstrb = 4'h0;
    bus_b.i_req_valid = 1'b0; bus_b.i_addr = 32'h0;
    bus_b.d_req_valid = 1'b0; bus_b.d_we = 1'b0; bus_b.d_addr = 32'h0;
    bus_b.d_wdata = 32'h0; bus_b.d_wstrb = 4'h0;
    rst = 1'b1;
    init_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    zero_a("reset_a");
    zero_check("reset_b", {bus_b.busy, bus_b.i_req_ready, bus_b.d_req_ready, bus_b.m_en, bus_b.m_we,
                           bus_b.i_rsp_valid, bus_b.d_rsp_valid, bus_b.m_wstrb},
               bus_b.m_addr, bus_b.m_wdata, bus_b.i_rdata, bus_b.d_rdata);
    init_mem = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single transactions: fetch alignment, load, partial store, zero-strobe store
    a_fetch(32'h0000_0106, 32'hDEAD_BEEF);
    a_data(1'b0, 32'h24, 32'h0, 4'h0, 32'hA009_0009);
    a_data(1'b1, 32'h20, 32'h1122_3344, 4'b0011, 32'hA009_0009);
    check("i_rdata_hold", bus_a.i_rdata, 32'hDEAD_BEEF);
    a_data(1'b0, 32'h20, 32'h0, 4'h0, 32'hA008_3344);
    a_data(1'b1, 32'h28, 32'hFFFF_FFFF, 4'b0000, 32'hA008_3344);
    a_data(1'b0, 32'h28, 32'h0, 4'h0, 32'hA00A_000A);

    // Both ports valid continuously: data streak limited to 4
    grant_log.delete();
    fork
      begin
        a_fetch_req(32'h80, pat(32));
        a_fetch_req(32'h84, pat(33));
        bus_a.i_req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 8; k++) a_data_req(1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'h0, pat(16 + k));
        bus_a.d_req_valid = 1'b0;
      end
    join
    drain_a();
    exp_order = "DDDDIDDDDI";
    check("grant_count", grant_log.size(), 10);
    n = (grant_log.size() < 10) ? grant_log.size() : 10;
    for (int k = 0; k < n; k++) check($sformatf("grant_%0d", k), grant_log[k], exp_order[k]);

    // Reset while a load sits in WAIT; streak must restart at zero
    grant_log.delete();
    fork
      begin
        a_fetch_req(32'h88, pat(34));
        bus_a.i_req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) a_data_req(1'b0, 32'h60 + 32'(4 * k), 32'h0, 4'h0, pat(24 + k));
        m = {1'b0, 32'h6C, 32'h0, 4'h0};
        d_m_q.push_back(m);
        bus_a.d_addr = 32'h6C;
        wait_ready_a(1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        zero_a("rst_in_wait");
        m = {1'b0, 32'h70, 32'h0, 4'h0};
        d_m_q.push_back(m);
        d_rsp_q.push_back(pat(28));
        bus_a.d_addr = 32'h70;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready_a(1'b1);
        bus_a.d_req_valid = 1'b0;
      end
    join
    drain_a();
    exp_order = "DDDDDI";
    check("rst_grant_count", grant_log.size(), 6);
    n = (grant_log.size() < 6) ? grant_log.size() : 6;
    for (int k = 0; k < n; k++) check($sformatf("rst_grant_%0d", k), grant_log[k], exp_order[k]);

    // RAM_LAT=3 load on the second instance
    b_rsp_q.push_back(32'hA5A5_A5A5);
    bus_b.d_addr      = 32'h30;
    bus_b.d_req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_b.d_req_ready && n < 50);
    check("b_accept", bus_b.d_req_ready, 1);
    check("b_busy_c0", bus_b.busy, 0);
    @(posedge clk);
    #1;
    bus_b.d_req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("b_busy_c%0d", c), bus_b.busy, (c <= 5) ? 1 : 0);
      if (c == 1) check("b_m_en_c1", {bus_b.m_en, bus_b.m_we, bus_b.m_addr}, {2'b10, 32'h30});
      if (c == 2) check("b_m_en_c2", bus_b.m_en, 0);
    end

    repeat (3) @(posedge clk);
    check("queues_empty", i_rsp_q.size() + d_rsp_q.size() + b_rsp_q.size() + i_m_q.size() + d_m_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
